// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared state encoding, parity codes and width helper for the UART TX frame engine
package uart_tx_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;
    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) ;
        return r;
    endfunction
endpackage

// File: rtl/uart_tx_frame_sequencer_if.sv
// uart_tx_frame_sequencer_if: TX handshake, frame config and line/status signals of the frame engine
interface uart_tx_frame_sequencer_if import uart_tx_pkg::*; #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
);
    localparam int IW = clog2(DATA_WIDTH);
    logic                      Data_Valid;
    logic [DATA_WIDTH-1:0]     P_Data;
    logic [PRESCALE_WIDTH-1:0] Prescale;
    logic                      Par_En;
    logic                      Par_Typ;
    logic                      Stop2;
    logic                      TX_OUT;
    logic                      Busy;
    logic [IW-1:0]             Bit_Index;
    logic                      Frame_Done;
    modport master (
        output Data_Valid, P_Data, Prescale, Par_En, Par_Typ, Stop2,
        input  TX_OUT, Busy, Bit_Index, Frame_Done
    );
    modport slave (
        input  Data_Valid, P_Data, Prescale, Par_En, Par_Typ, Stop2,
        output TX_OUT, Busy, Bit_Index, Frame_Done
    );
endinterface

// File: rtl/uart_tx_bit_timer.sv
// uart_tx_bit_timer: counts 0..P-1 while enabled and ticks on the last clock of each bit period
module uart_tx_bit_timer #(
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      RST,
    input  logic                      enable,
    input  logic [PRESCALE_WIDTH-1:0] P,
    output logic                      bit_end
);
    logic [PRESCALE_WIDTH-1:0] cnt;
    assign bit_end = enable && cnt == P - 1'b1;
    always_ff @(posedge clk)
        cnt <= (RST || !enable || bit_end) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx_frame_sequencer.sv
// uart_tx_frame_sequencer: sequences start, LSB-first data, optional parity and 1/2 stop bits onto TX_OUT
module uart_tx_frame_sequencer import uart_tx_pkg::*; #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input logic                     clk,
    input logic                     RST,
    uart_tx_frame_sequencer_if.slave bus
);
    localparam int IW = clog2(DATA_WIDTH);
    state_t                    state, state_n;
    logic [DATA_WIDTH-1:0]     data_q;
    logic [PRESCALE_WIDTH-1:0] p_q;
    logic [IW-1:0]             idx, idx_n;
    logic                      par_en_q, par_typ_q, stop2_q;
    logic                      stop_cnt, stop_cnt_n;
    logic                      tx_q, tx_n, busy_q, bit_end, accept, parity;
    assign accept = state == IDLE && bus.Data_Valid;
    assign parity = ^data_q ^ (par_typ_q == PAR_ODD);
    uart_tx_bit_timer #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_timer (
        .clk(clk), .RST(RST), .enable(state != IDLE), .P(p_q), .bit_end(bit_end)
    );
    always_comb begin
        state_n    = state;
        idx_n      = idx;
        stop_cnt_n = stop_cnt;
        case (state)
            IDLE:   if (bus.Data_Valid) state_n = START;
            START:  if (bit_end) state_n = DATA;
            DATA:   if (bit_end) begin
                        if (idx == IW'(DATA_WIDTH - 1)) begin
                            state_n = par_en_q ? PARITY : STOP;
                            idx_n   = '0;
                        end else idx_n = idx + 1'b1;
                    end
            PARITY: if (bit_end) state_n = STOP;
            STOP:   if (bit_end) begin
                        if (stop2_q && !stop_cnt) stop_cnt_n = 1'b1;
                        else begin
                            state_n    = IDLE;
                            stop_cnt_n = 1'b0;
                        end
                    end
            default: state_n = IDLE;
        endcase
        // line level is registered from the next state so TX_OUT never decodes inputs
        tx_n = state_n == START  ? 1'b0 :
               state_n == DATA   ? data_q[idx_n] :
               state_n == PARITY ? parity : 1'b1;
    end
    always_ff @(posedge clk) begin
        if (RST) begin
            state     <= IDLE;
            idx       <= '0;
            stop_cnt  <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            data_q    <= '0;
            p_q       <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            stop2_q   <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            stop_cnt <= stop_cnt_n;
            tx_q     <= tx_n;
            busy_q   <= state_n != IDLE;
            if (accept) begin
                data_q    <= bus.P_Data;
                p_q       <= (bus.Prescale == '0) ? PRESCALE_WIDTH'(1) : bus.Prescale;
                par_en_q  <= bus.Par_En;
                par_typ_q <= bus.Par_Typ;
                stop2_q   <= bus.Stop2;
            end
        end
    end
    assign bus.TX_OUT     = tx_q;
    assign bus.Busy       = busy_q;
    assign bus.Bit_Index  = idx;
    assign bus.Frame_Done = state == STOP && bit_end && (!stop2_q || stop_cnt);
endmodule

// File: tb/tb_uart_tx_frame_sequencer.sv
// tb_uart_tx_frame_sequencer: directed frames with hand-computed line patterns, lengths and timing
module tb_uart_tx_frame_sequencer;
    logic clk = 1'b0;
    logic RST = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    always #5 clk = ~clk;
    uart_tx_frame_sequencer_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) bus ();
    uart_tx_frame_sequencer #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
        .clk(clk), .RST(RST), .bus(bus)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic start(input logic [7:0] d, input logic [5:0] ps, input logic pe, input logic pt,
                         input logic s2, input logic hold);
        @(negedge clk);
        bus.P_Data     = d;
        bus.Prescale   = ps;
        bus.Par_En     = pe;
        bus.Par_Typ    = pt;
        bus.Stop2      = s2;
        bus.Data_Valid = 1'b1;
        @(posedge clk);
        #1 if (!hold) bus.Data_Valid = 1'b0;
    endtask
    // eb holds the expected line level of bit-period i in bit i (bit 0 = start bit)
    task automatic monitor(input string tag, input int p, input logic [15:0] eb, input int elen);
        logic [15:0] ob = '0;
        int len = 0, uns = 0, ibad = 0, dcnt = 0, dpos = 0, b, ei;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!bus.Busy) break;
            len++;
            b = (len - 1) / p;
            if (b < 16) begin
                if ((len - 1) % p == 0) ob[b] = bus.TX_OUT;
                else if (bus.TX_OUT !== ob[b]) uns++;
            end
            ei = (b >= 1 && b <= 8) ? b - 1 : 0;
            if (32'(bus.Bit_Index) != ei) ibad++;
            if (bus.Frame_Done) begin
                dcnt++;
                dpos = len;
            end
        end
        check({tag, "_bits"}, 32'(ob), 32'(eb));
        check({tag, "_len"}, 32'(len), 32'(elen));
        check({tag, "_done_count"}, 32'(dcnt), 32'd1);
        check({tag, "_done_pos"}, 32'(dpos), 32'(elen));
        check({tag, "_unstable"}, 32'(uns), 32'd0);
        check({tag, "_bit_index"}, 32'(ibad), 32'd0);
        check({tag, "_idle_tx"}, 32'(bus.TX_OUT), 32'd1);
        check({tag, "_idle_done"}, 32'(bus.Frame_Done), 32'd0);
    endtask
    initial begin
        int dc, bc;
        bus.Data_Valid = 1'b0;
        bus.P_Data     = '0;
        bus.Prescale   = 6'd1;
        bus.Par_En     = 1'b0;
        bus.Par_Typ    = 1'b0;
        bus.Stop2      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tx", 32'(bus.TX_OUT), 32'd1);
        check("rst_busy", 32'(bus.Busy), 32'd0);
        check("rst_idx", 32'(bus.Bit_Index), 32'd0);
        check("rst_done", 32'(bus.Frame_Done), 32'd0);
        RST = 1'b0;
        // 0xA5, P=1, 8N1: 0,1,0,1,0,0,1,0,1,1
        start(8'hA5, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        monitor("a5_p1", 1, 16'h034A, 10);
        // 0x03, P=4, even parity -> parity 0, 11 bits x 4
        start(8'h03, 6'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        monitor("03_p4_even", 4, 16'h0406, 44);
        // 0x07, P=2, odd parity -> parity 0, two stop bits
        start(8'h07, 6'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        monitor("07_p2_odd_s2", 2, 16'h0C0E, 24);
        // 0x01, P=3, even parity -> parity 1
        start(8'h01, 6'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        monitor("01_p3_even", 3, 16'h0602, 33);
        // second request mid-frame with other data/config must be ignored
        fork
            begin
                start(8'hA5, 6'd2, 1'b0, 1'b0, 1'b0, 1'b0);
                monitor("ignore_mid", 2, 16'h034A, 20);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                bus.P_Data     = 8'hFF;
                bus.Prescale   = 6'd1;
                bus.Par_En     = 1'b1;
                bus.Data_Valid = 1'b1;
                @(posedge clk);
                #1 bus.Data_Valid = 1'b0;
            end
        join
        // reset during data bit 3 aborts the frame
        start(8'hA5, 6'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 100 && bus.Bit_Index != 3'd3; c++) @(negedge clk);
        check("abort_reach_bit3", 32'(bus.Bit_Index), 32'd3);
        RST = 1'b1;
        @(negedge clk);
        check("abort_tx", 32'(bus.TX_OUT), 32'd1);
        check("abort_busy", 32'(bus.Busy), 32'd0);
        check("abort_idx", 32'(bus.Bit_Index), 32'd0);
        check("abort_done", 32'(bus.Frame_Done), 32'd0);
        RST = 1'b0;
        dc = 0;
        bc = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.Frame_Done) dc++;
            if (bus.Busy) bc++;
        end
        check("abort_no_done", 32'(dc), 32'd0);
        check("abort_stays_idle", 32'(bc), 32'd0);
        start(8'hA5, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        monitor("after_abort", 1, 16'h034A, 10);
        // Data_Valid held high, Prescale=0 -> P=1, one idle-high cycle between frames
        start(8'hA5, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        monitor("b2b_first", 1, 16'h034A, 10);
        fork
            monitor("b2b_second", 1, 16'h034A, 10);
            begin
                @(posedge clk);
                #1 bus.Data_Valid = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        check("b2b_no_third", 32'(bus.Busy), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
